// File: rtl/imm_gen_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module      : imm_gen_pipe_if
//  Description : Valid/ready bundle between instruction fetch, the pipelined
//                immediate generator and the decode/execute stage.
//  Revision    : 1.0  initial release
// ============================================================================
interface imm_gen_pipe_if #(
    parameter int XLEN  = 64,
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_imm;
    logic [2:0]       out_fmt;
    logic [TAG_W-1:0] out_tag;

    // Upstream/downstream environment side
    modport master (
        output in_valid, in_instr, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_fmt, out_tag
    );

    // Immediate generator side
    modport slave (
        input  in_valid, in_instr, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_fmt, out_tag
    );
endinterface
`default_nettype wire

// File: rtl/imm_gen_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : imm_gen_pipe
//  Description : Pipelined RV32I/RV64I immediate extractor. Decodes I/S/B/U/J
//                immediates from the opcode, sign-extends to XLEN and queues
//                the result in a 2-entry skid buffer behind valid/ready.
//                Optional macro IMM_GEN_PIPE_ERRCNT_EN adds a saturating
//                16-bit count of illegal-opcode words delivered downstream.
//  Revision    : 1.0  initial release
// ============================================================================
module imm_gen_pipe #(
    parameter int XLEN  = 64,
    parameter int TAG_W = 5
) (
    input  wire logic     clk,
    input  wire logic     reset_n,
    imm_gen_pipe_if.slave bus
`ifdef IMM_GEN_PIPE_ERRCNT_EN
    ,
    output logic [15:0]   err_count
`endif
);

    localparam logic [2:0] c_fmt_i   = 3'd0;
    localparam logic [2:0] c_fmt_s   = 3'd1;
    localparam logic [2:0] c_fmt_b   = 3'd2;
    localparam logic [2:0] c_fmt_u   = 3'd3;
    localparam logic [2:0] c_fmt_j   = 3'd4;
    localparam logic [2:0] c_fmt_ill = 3'd7;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_t;

    logic [31:0]      w_instr;
    logic [31:0]      w_imm32;
    logic [XLEN-1:0]  w_imm;
    logic [2:0]       w_fmt;
    logic             w_push;
    logic             w_pop;
    logic             w_tail;
    occ_t             w_state_next;

    occ_t             r_state;
    logic             r_head;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [XLEN-1:0]  r_mem_imm [2];
    logic [2:0]       r_mem_fmt [2];
    logic [TAG_W-1:0] r_mem_tag [2];

    assign w_instr = bus.in_instr;

    // Immediate decode from opcode, built as a 32-bit sign-extended value
    always_comb begin
        w_fmt   = c_fmt_ill;
        w_imm32 = '0;
        case (w_instr[6:0])
            7'b0000011, 7'b0010011, 7'b0011011, 7'b1100111: begin
                w_fmt   = c_fmt_i;
                w_imm32 = {{20{w_instr[31]}}, w_instr[31:20]};
            end
            7'b0100011: begin
                w_fmt   = c_fmt_s;
                w_imm32 = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
            end
            7'b1100011: begin
                w_fmt   = c_fmt_b;
                w_imm32 = {{19{w_instr[31]}}, w_instr[31], w_instr[7],
                           w_instr[30:25], w_instr[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                w_fmt   = c_fmt_u;
                w_imm32 = {w_instr[31:12], 12'b0};
            end
            7'b1101111: begin
                w_fmt   = c_fmt_j;
                w_imm32 = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12],
                           w_instr[20], w_instr[30:21], 1'b0};
            end
            default: begin
                w_fmt   = c_fmt_ill;
                w_imm32 = '0;
            end
        endcase
    end

    // Every format is sign-extended from bit 31, so widening is a plain replicate
    generate
        if (XLEN == 64) begin : g_xlen64
            assign w_imm = {{(XLEN-32){w_imm32[31]}}, w_imm32};
        end else begin : g_xlen32
            assign w_imm = w_imm32;
        end
    endgenerate

    assign w_push = bus.in_valid && r_in_ready;
    assign w_pop  = r_out_valid && bus.out_ready;
    // Tail sits one past the head only when a single entry is held
    assign w_tail = r_head ^ (r_state == ONE);

    // Occupancy next state; simultaneous push and pop leaves it unchanged
    always_comb begin
        w_state_next = r_state;
        case ({w_push, w_pop})
            2'b10:   w_state_next = (r_state == EMPTY) ? ONE : FULL;
            2'b01:   w_state_next = (r_state == FULL) ? ONE : EMPTY;
            default: w_state_next = r_state;
        endcase
    end

    // Skid buffer storage, head pointer and registered handshake flags
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= EMPTY;
            r_head       <= 1'b0;
            r_in_ready   <= 1'b1;
            r_out_valid  <= 1'b0;
            r_mem_imm[0] <= '0;
            r_mem_imm[1] <= '0;
            r_mem_fmt[0] <= '0;
            r_mem_fmt[1] <= '0;
            r_mem_tag[0] <= '0;
            r_mem_tag[1] <= '0;
        end else begin
            r_state     <= w_state_next;
            r_in_ready  <= (w_state_next != FULL);
            r_out_valid <= (w_state_next != EMPTY);
            if (w_pop) begin
                r_head <= ~r_head;
            end
            if (w_push) begin
                r_mem_imm[w_tail] <= w_imm;
                r_mem_fmt[w_tail] <= w_fmt;
                r_mem_tag[w_tail] <= bus.in_tag;
            end
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_imm   = r_mem_imm[r_head];
    assign bus.out_fmt   = r_mem_fmt[r_head];
    assign bus.out_tag   = r_mem_tag[r_head];

`ifdef IMM_GEN_PIPE_ERRCNT_EN
    logic [15:0] r_err_count;

    // Saturating count of illegal-opcode words handed downstream
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err_count <= '0;
        end else if (w_pop && (bus.out_fmt == c_fmt_ill) && (r_err_count != 16'hFFFF)) begin
            r_err_count <= r_err_count + 16'd1;
        end
    end

    assign err_count = r_err_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imm_gen_pipe
//  Description : Scoreboard bench for imm_gen_pipe. Drives one stimulus stream
//                into an XLEN=64 and an XLEN=32 instance in parallel and
//                checks both against an arithmetic reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_imm_gen_pipe;

    typedef struct packed {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic [4:0]  tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [4:0]  in_tag;
    logic        out_ready;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    exp_t q64[$];
    exp_t q32[$];

    imm_gen_pipe_if #(.XLEN(64), .TAG_W(5)) bus64();
    imm_gen_pipe_if #(.XLEN(32), .TAG_W(5)) bus32();

    assign bus64.in_valid  = in_valid;
    assign bus64.in_instr  = in_instr;
    assign bus64.in_tag    = in_tag;
    assign bus64.out_ready = out_ready;
    assign bus32.in_valid  = in_valid;
    assign bus32.in_instr  = in_instr;
    assign bus32.in_tag    = in_tag;
    assign bus32.out_ready = out_ready;

`ifdef IMM_GEN_PIPE_ERRCNT_EN
    logic [15:0] err64;
    logic [15:0] err32;
    imm_gen_pipe #(.XLEN(64), .TAG_W(5)) dut64 (.clk(clk), .reset_n(reset_n), .bus(bus64), .err_count(err64));
    imm_gen_pipe #(.XLEN(32), .TAG_W(5)) dut32 (.clk(clk), .reset_n(reset_n), .bus(bus32), .err_count(err32));
`else
    imm_gen_pipe #(.XLEN(64), .TAG_W(5)) dut64 (.clk(clk), .reset_n(reset_n), .bus(bus64));
    imm_gen_pipe #(.XLEN(32), .TAG_W(5)) dut32 (.clk(clk), .reset_n(reset_n), .bus(bus32));
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference: immediate as a signed integer value, scaled by the format's shift
    function automatic exp_t ref_model(input logic [31:0] ins, input logic [4:0] tag);
        exp_t   e;
        longint v;
        logic [2:0] f;
        case (ins[6:0])
            7'b0000011, 7'b0010011, 7'b0011011, 7'b1100111: begin
                f = 3'd0; v = longint'($signed(ins[31:20]));
            end
            7'b0100011: begin
                f = 3'd1; v = longint'($signed({ins[31:25], ins[11:7]}));
            end
            7'b1100011: begin
                f = 3'd2; v = longint'($signed({ins[31], ins[7], ins[30:25], ins[11:8]})) * 2;
            end
            7'b0110111, 7'b0010111: begin
                f = 3'd3; v = longint'($signed(ins[31:12])) * 4096;
            end
            7'b1101111: begin
                f = 3'd4; v = longint'($signed({ins[31], ins[19:12], ins[20], ins[30:21]})) * 2;
            end
            default: begin
                f = 3'd7; v = 0;
            end
        endcase
        e.imm = v;
        e.fmt = f;
        e.tag = tag;
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [6:0]  op;
        w = $urandom;
        case ($urandom_range(0, 11))
            0:  op = 7'b0000011;
            1:  op = 7'b0010011;
            2:  op = 7'b0011011;
            3:  op = 7'b1100111;
            4:  op = 7'b0100011;
            5:  op = 7'b1100011;
            6:  op = 7'b0110111;
            7:  op = 7'b0010111;
            8:  op = 7'b1101111;
            default: op = w[6:0];
        endcase
        w[6:0] = op;
        return w;
    endfunction

    // Present one word, hold it until accepted, record expectation on acceptance
    task automatic drive(input logic [31:0] ins, input logic [4:0] tag, input exp_t e);
        in_valid = 1'b1;
        in_instr = ins;
        in_tag   = tag;
        for (int n = 0; n < 64; n++) begin
            @(negedge clk);
            if (bus64.in_ready) begin
                q64.push_back(e);
                if (bus32.in_ready) q32.push_back(e);
                @(posedge clk);
                #1;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL accept_timeout: actual=in_ready low for 64 cycles required=accept tag %0d", tag);
        in_valid = 1'b0;
    endtask

    task automatic send_exp(input logic [31:0] ins, input logic [4:0] tag,
                            input logic [63:0] imm, input logic [2:0] fmt);
        exp_t e;
        e.imm = imm;
        e.fmt = fmt;
        e.tag = tag;
        drive(ins, tag, e);
    endtask

    task automatic send_rand(input logic [4:0] tag);
        logic [31:0] ins;
        ins = rand_instr();
        drive(ins, tag, ref_model(ins, tag));
    endtask

    task automatic drain();
        for (int n = 0; n < 200; n++) begin
            if (q64.size() == 0 && q32.size() == 0) return;
            @(posedge clk);
            #1;
        end
        checks++;
        errors++;
        $display("FAIL drain_timeout: actual=%0d/%0d entries pending required=0", q64.size(), q32.size());
        q64.delete();
        q32.delete();
    endtask

    // Monitor: pops the scoreboard on every output transfer, checks holds are stable
    logic        hold64 = 1'b0, hold32 = 1'b0;
    logic [79:0] held64, held32;
    always @(negedge clk) begin
        exp_t e;
        if (!reset_n) begin
            hold64 = 1'b0;
            hold32 = 1'b0;
        end else begin
            if (hold64) chk("stable64", {7'd0, bus64.out_valid, bus64.out_fmt, bus64.out_tag, bus64.out_imm}, held64);
            if (hold32) chk("stable32", {39'd0, bus32.out_valid, bus32.out_fmt, bus32.out_tag, bus32.out_imm}, held32);
            if (bus64.out_valid && out_ready) begin
                if (q64.size() == 0) chk("unexpected64", 80'd1, 80'd0);
                else begin
                    e = q64.pop_front();
                    chk("out64", {8'd0, bus64.out_fmt, bus64.out_tag, bus64.out_imm}, {8'd0, e.fmt, e.tag, e.imm});
                end
            end
            if (bus32.out_valid && out_ready) begin
                if (q32.size() == 0) chk("unexpected32", 80'd1, 80'd0);
                else begin
                    e = q32.pop_front();
                    chk("out32", {40'd0, bus32.out_fmt, bus32.out_tag, bus32.out_imm}, {40'd0, e.fmt, e.tag, e.imm[31:0]});
                end
            end
            hold64 = bus64.out_valid && !out_ready;
            hold32 = bus32.out_valid && !out_ready;
            held64 = {7'd0, bus64.out_valid, bus64.out_fmt, bus64.out_tag, bus64.out_imm};
            held32 = {39'd0, bus32.out_valid, bus32.out_fmt, bus32.out_tag, bus32.out_imm};
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: actual=simulation still running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  t0;
        bit  rnd_done;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        // Reset state
        chk("rst_valid", {78'd0, bus64.out_valid, bus32.out_valid}, 80'd0);
        chk("rst_ready", {78'd0, bus64.in_ready, bus32.in_ready}, 80'd3);
        chk("rst_out64", {8'd0, bus64.out_fmt, bus64.out_tag, bus64.out_imm}, 80'd0);
        chk("rst_out32", {40'd0, bus32.out_fmt, bus32.out_tag, bus32.out_imm}, 80'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed formats, one at a time, visible right after acceptance
        send_exp(32'hFFF02083, 5'd1, 64'hFFFFFFFFFFFFFFFF, 3'd0);
        chk("lat_lw", {79'd0, bus64.out_valid}, 80'd1);
        in_valid = 1'b0; @(posedge clk); #1;
        send_exp(32'hFE113C23, 5'd2, 64'hFFFFFFFFFFFFFFF8, 3'd1);
        chk("lat_sd", {79'd0, bus32.out_valid}, 80'd1);
        in_valid = 1'b0; @(posedge clk); #1;
        send_exp(32'h00000863, 5'd3, 64'h0000000000000010, 3'd2);
        in_valid = 1'b0; @(posedge clk); #1;
        send_exp(32'h123450B7, 5'd4, 64'h0000000012345000, 3'd3);
        in_valid = 1'b0; @(posedge clk); #1;
        send_exp(32'h800000B7, 5'd5, 64'hFFFFFFFF80000000, 3'd3);
        in_valid = 1'b0; @(posedge clk); #1;
        send_exp(32'hFFDFF06F, 5'd6, 64'hFFFFFFFFFFFFFFFC, 3'd4);
        in_valid = 1'b0; @(posedge clk); #1;
        send_exp(32'h00000000, 5'd7, 64'h0, 3'd7);
        in_valid = 1'b0;
        drain();

        // Back-to-back stream: 8 words in 8 cycles
        t0 = cyc;
        for (int i = 0; i < 8; i++) send_rand(5'(i));
        chk("b2b_cycles", 80'(cyc - t0), 80'd8);
        in_valid = 1'b0;
        drain();

        // Backpressure: two accepts fill the buffer, third waits
        out_ready = 1'b0;
        send_rand(5'd0);
        send_rand(5'd1);
        chk("full_ready", {78'd0, bus64.in_ready, bus32.in_ready}, 80'd0);
        chk("full_head", {75'd0, bus64.out_tag}, 80'd0);
        fork
            send_rand(5'd2);
            begin
                repeat (3) @(posedge clk);
                #1;
                chk("held_head", {75'd0, bus32.out_tag}, 80'd0);
                out_ready = 1'b1;
            end
        join
        in_valid = 1'b0;
        drain();

        // Asynchronous reset while full
        out_ready = 1'b0;
        send_rand(5'd9);
        send_rand(5'd10);
        in_valid = 1'b0;
        #3;
        reset_n = 1'b0;
        #1;
        chk("arst_valid", {78'd0, bus64.out_valid, bus32.out_valid}, 80'd0);
        chk("arst_ready", {78'd0, bus64.in_ready, bus32.in_ready}, 80'd3);
        q64.delete();
        q32.delete();
        @(posedge clk);
        #1;
        reset_n   = 1'b1;
        out_ready = 1'b1;
        send_exp(32'h123450B7, 5'd11, 64'h0000000012345000, 3'd3);
        in_valid = 1'b0;
        drain();

        // Randomized traffic with random backpressure
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    send_rand(5'($urandom));
                    if ($urandom_range(0, 3) == 0) begin
                        in_valid = 1'b0;
                        @(posedge clk);
                        #1;
                    end
                end
                in_valid = 1'b0;
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        drain();

`ifdef IMM_GEN_PIPE_ERRCNT_EN
        reset_n = 1'b0;
        #1;
        reset_n = 1'b1;
        chk("err_rst", {48'd0, err64, err32}, 80'd0);
        @(posedge clk);
        #1;
        send_exp(32'h00000000, 5'd1, 64'h0, 3'd7);
        in_valid = 1'b0;
        drain();
        @(posedge clk);
        #1;
        chk("err_one", {48'd0, err64, err32}, {48'd0, 16'd1, 16'd1});
        for (int i = 0; i < 32'h10000; i++) send_exp(32'h00000000, 5'd2, 64'h0, 3'd7);
        in_valid = 1'b0;
        drain();
        @(posedge clk);
        #1;
        chk("err_sat", {48'd0, err64, err32}, {48'd0, 16'hFFFF, 16'hFFFF});
`endif

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
